// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions: region codes, region bases and the router FSM state type.
package mem_map_pkg;

  localparam int unsigned RAM_STATE = 1;
  localparam int unsigned VGA_STATE = 2;
  localparam int unsigned ERR_STATE = 3;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] VGA_BASE = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAM_WAIT  = 3'd1,
    VGA_ISSUE = 3'd2,
    VGA_CAPT  = 3'd3,
    RESP      = 3'd4
  } router_state_e;

  typedef enum logic [1:0] {
    REGION_RAM = 2'd0,
    REGION_VGA = 2'd1,
    REGION_ERR = 2'd2
  } region_e;

endpackage

// File: rtl/mem_bus_router_if.sv
// CPU request/response, RAM port and VGA port bundle seen by the router.
interface mem_bus_router_if #(
  parameter int word_width = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [word_width-1:0] req_addr;
  logic [word_width-1:0] req_state;
  logic [word_width-1:0] req_wdata;

  logic                  resp_valid;
  logic [word_width-1:0] resp_rdata;
  logic                  resp_err;

  logic                  ram_req;
  logic                  ram_we;
  logic [word_width-1:0] ram_addr;
  logic [word_width-1:0] ram_wdata;
  logic                  ram_ack;
  logic [word_width-1:0] ram_rdata;

  logic                  vga_en;
  logic                  vga_we;
  logic [word_width-1:0] vga_addr;
  logic [word_width-1:0] vga_wdata;
  logic [word_width-1:0] vga_rdata;

  // The router itself.
  modport slave (
    input  req_valid, req_we, req_addr, req_state, req_wdata,
    input  ram_ack, ram_rdata, vga_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_req, ram_we, ram_addr, ram_wdata,
    output vga_en, vga_we, vga_addr, vga_wdata
  );

  // The CPU and memories around the router.
  modport master (
    output req_valid, req_we, req_addr, req_state, req_wdata,
    output ram_ack, ram_rdata, vga_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    input  vga_en, vga_we, vga_addr, vga_wdata
  );

endinterface

// File: rtl/mem_bus_router_ram_timeout_ctr.sv
// Up-counter bounding how long a RAM request may wait for ram_ack.
module ram_timeout_ctr #(
  parameter int ram_timeout = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int cw = (ram_timeout > 2) ? $clog2(ram_timeout) : 1;

  logic [cw-1:0] cnt;

  assign expired = (cnt == cw'(ram_timeout - 1));

  // Saturates at the terminal count so a stalled caller never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + cw'(1);
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// Routes one translated CPU access at a time to RAM (ack handshake, timeout) or the
// VGA framebuffer (fixed 1-cycle read latency) and returns a single-cycle response.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | ready for a request; response strobe may be high this cycle
//   RAM_WAIT  | ram_req held, waiting for ram_ack or timeout
//   VGA_ISSUE | vga_en strobe high
//   VGA_CAPT  | capturing vga_rdata
//   RESP      | result latched; resp_valid rises on the next edge
module mem_bus_router
  import mem_map_pkg::*;
#(
  parameter int word_width  = 32,
  parameter int ram_timeout = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_bus_router_if.slave bus
);

  typedef logic [word_width-1:0] word_t;

  router_state_e state, nxt_state;
  region_e       region;

  logic  we_q, nxt_we_q;
  logic  resp_valid_q, nxt_resp_valid;
  logic  resp_err_q, nxt_resp_err;
  word_t resp_rdata_q, nxt_resp_rdata;
  logic  ram_req_q, nxt_ram_req;
  logic  ram_we_q, nxt_ram_we;
  word_t ram_addr_q, nxt_ram_addr;
  word_t ram_wdata_q, nxt_ram_wdata;
  logic  vga_en_q, nxt_vga_en;
  logic  vga_we_q, nxt_vga_we;
  word_t vga_addr_q, nxt_vga_addr;
  word_t vga_wdata_q, nxt_vga_wdata;

  logic ctr_clr, ctr_en, ctr_expired;

  always_comb begin
    region = REGION_ERR;
    if (bus.req_state == word_width'(RAM_STATE)) begin
      region = REGION_RAM;
    end else if (bus.req_state == word_width'(VGA_STATE)) begin
      region = REGION_VGA;
    end
  end

  assign ctr_clr = (state != RAM_WAIT);
  assign ctr_en  = (state == RAM_WAIT) && !bus.ram_ack;

  ram_timeout_ctr #(
    .ram_timeout(ram_timeout)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expired(ctr_expired)
  );

  always_comb begin
    nxt_state      = state;
    nxt_we_q       = we_q;
    nxt_resp_valid = 1'b0;
    nxt_resp_err   = resp_err_q;
    nxt_resp_rdata = resp_rdata_q;
    nxt_ram_req    = ram_req_q;
    nxt_ram_we     = ram_we_q;
    nxt_ram_addr   = ram_addr_q;
    nxt_ram_wdata  = ram_wdata_q;
    nxt_vga_en     = 1'b0;
    nxt_vga_we     = vga_we_q;
    nxt_vga_addr   = vga_addr_q;
    nxt_vga_wdata  = vga_wdata_q;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          nxt_we_q = bus.req_we;
          case (region)
            REGION_RAM: begin
              nxt_state     = RAM_WAIT;
              nxt_ram_req   = 1'b1;
              nxt_ram_we    = bus.req_we;
              nxt_ram_addr  = bus.req_addr;
              nxt_ram_wdata = bus.req_wdata;
            end
            REGION_VGA: begin
              nxt_state     = VGA_ISSUE;
              nxt_vga_en    = 1'b1;
              nxt_vga_we    = bus.req_we;
              nxt_vga_addr  = bus.req_addr;
              nxt_vga_wdata = bus.req_wdata;
            end
            default: begin
              nxt_state      = RESP;
              nxt_resp_err   = 1'b1;
              nxt_resp_rdata = '0;
            end
          endcase
        end
      end
      // An ack on the expiry cycle still completes the access normally.
      RAM_WAIT: begin
        if (bus.ram_ack) begin
          nxt_state      = RESP;
          nxt_ram_req    = 1'b0;
          nxt_resp_err   = 1'b0;
          nxt_resp_rdata = we_q ? '0 : bus.ram_rdata;
        end else if (ctr_expired) begin
          nxt_state      = RESP;
          nxt_ram_req    = 1'b0;
          nxt_resp_err   = 1'b1;
          nxt_resp_rdata = '0;
        end
      end
      VGA_ISSUE: begin
        nxt_state = VGA_CAPT;
      end
      VGA_CAPT: begin
        nxt_state      = RESP;
        nxt_resp_err   = 1'b0;
        nxt_resp_rdata = we_q ? '0 : bus.vga_rdata;
      end
      RESP: begin
        nxt_state      = IDLE;
        nxt_resp_valid = 1'b1;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      vga_en_q     <= 1'b0;
      vga_we_q     <= 1'b0;
      vga_addr_q   <= '0;
      vga_wdata_q  <= '0;
    end else begin
      state        <= nxt_state;
      we_q         <= nxt_we_q;
      resp_valid_q <= nxt_resp_valid;
      resp_err_q   <= nxt_resp_err;
      resp_rdata_q <= nxt_resp_rdata;
      ram_req_q    <= nxt_ram_req;
      ram_we_q     <= nxt_ram_we;
      ram_addr_q   <= nxt_ram_addr;
      ram_wdata_q  <= nxt_ram_wdata;
      vga_en_q     <= nxt_vga_en;
      vga_we_q     <= nxt_vga_we;
      vga_addr_q   <= nxt_vga_addr;
      vga_wdata_q  <= nxt_vga_wdata;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ram_req    = ram_req_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.vga_en     = vga_en_q;
  assign bus.vga_we     = vga_we_q;
  assign bus.vga_addr   = vga_addr_q;
  assign bus.vga_wdata  = vga_wdata_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Bench for mem_bus_router: table of accesses checked through a response scoreboard,
// with RAM/VGA stand-ins, plus hand-written reset sequences.
module tb_mem_bus_router;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_router_if #(.word_width(32)) bus ();

  mem_bus_router #(
    .word_width (32),
    .ram_timeout(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] state;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_delay;
    logic [31:0] ram_data;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_ram;
    int          exp_vga;
  } vec_t;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          ram;
    int          vga;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];

  int          ack_delay = -1;
  logic [31:0] ack_data  = '0;
  bit          late_ack  = 1'b0;
  logic [31:0] vga_mem[256];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input logic we, input logic [31:0] st, input logic [31:0] ad,
                         input logic [31:0] wd, input int d, input logic [31:0] rd, input logic err,
                         input logic [31:0] rdat, input int lat, input int ram, input int vga);
    vecs[i] = '{we, st, ad, wd, d, rd, err, rdat, lat, ram, vga};
  endtask

  // RAM stand-in: ack d cycles after ram_req is first seen, never if d < 0.
  initial begin
    int  cnt;
    bit  acked;
    cnt   = 0;
    acked = 1'b0;
    forever begin
      @(negedge clk);
      bus.ram_ack   = late_ack;
      bus.ram_rdata = late_ack ? 32'h0BAD_0ACC : 32'hEEEE_0000 + 32'(cyc);
      if (bus.ram_req && !acked) begin
        if (ack_delay >= 0 && cnt == ack_delay) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = ack_data;
          acked         = 1'b1;
        end else begin
          cnt++;
        end
      end else if (!bus.ram_req) begin
        cnt   = 0;
        acked = 1'b0;
      end
    end
  end

  // VGA stand-in: read data valid exactly the cycle after vga_en, junk otherwise.
  initial begin
    bit       pend;
    bit [7:0] pa;
    pend = 1'b0;
    pa   = '0;
    forever begin
      @(negedge clk);
      bus.vga_rdata = 32'hBAD0_BAD0;
      if (pend) begin
        bus.vga_rdata = vga_mem[pa];
        pend          = 1'b0;
      end
      if (bus.vga_en) begin
        if (bus.vga_we) vga_mem[bus.vga_addr[7:0]] = bus.vga_wdata;
        else begin
          pend = 1'b1;
          pa   = bus.vga_addr[7:0];
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    int   ram_cyc;
    int   vga_cyc;
    exp_t e;
    ram_cyc = 0;
    vga_cyc = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.resp_valid) begin
        ram_cyc = 0;
        vga_cyc = 0;
      end
      if (bus.ram_req === 1'b1) begin
        ram_cyc++;
        if (sb_q.size() != 0) begin
          check($sformatf("v%0d ram_addr", sb_q[0].id), bus.ram_addr, sb_q[0].addr);
          check($sformatf("v%0d ram_we", sb_q[0].id), 32'(bus.ram_we), 32'(sb_q[0].we));
          check($sformatf("v%0d ram_wdata", sb_q[0].id), bus.ram_wdata, sb_q[0].wdata);
        end
      end
      if (bus.vga_en === 1'b1) begin
        vga_cyc++;
        if (sb_q.size() != 0) begin
          check($sformatf("v%0d vga_addr", sb_q[0].id), bus.vga_addr, sb_q[0].addr);
          check($sformatf("v%0d vga_we", sb_q[0].id), 32'(bus.vga_we), 32'(sb_q[0].we));
          check($sformatf("v%0d vga_wdata", sb_q[0].id), bus.vga_wdata, sb_q[0].wdata);
        end
      end
      if (bus.resp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected resp_valid", 32'(bus.resp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("v%0d resp_err", e.id), 32'(bus.resp_err), 32'(e.err));
          check($sformatf("v%0d resp_rdata", e.id), bus.resp_rdata, e.rdata);
          check($sformatf("v%0d resp_cycle", e.id), 32'(cyc), 32'(e.cyc));
          check($sformatf("v%0d ram_req_cycles", e.id), 32'(ram_cyc), 32'(e.ram));
          check($sformatf("v%0d vga_en_cycles", e.id), 32'(vga_cyc), 32'(e.vga));
        end
        ram_cyc = 0;
        vga_cyc = 0;
      end
    end
  end

  task automatic run_vec(input int id);
    vec_t v;
    exp_t e;
    int   k;
    v = vecs[id];
    @(negedge clk);
    for (k = 0; k < 40 && bus.req_ready !== 1'b1; k++) @(negedge clk);
    check($sformatf("v%0d req_ready before issue", id), 32'(bus.req_ready), 32'd1);
    ack_delay     = v.ack_delay;
    ack_data      = v.ram_data;
    bus.req_we    = v.we;
    bus.req_state = v.state;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_valid = 1'b1;
    e = '{id, v.we, v.addr, v.wdata, v.exp_err, v.exp_rdata, cyc + 1 + v.exp_lat, v.exp_ram, v.exp_vga};
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = ~v.we;
    bus.req_state = $urandom();
    bus.req_addr  = $urandom();
    bus.req_wdata = $urandom();
    for (k = 0; k < 60 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check($sformatf("v%0d response timeout, pending", id), 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
    check({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, " ram_req"}, 32'(bus.ram_req), 32'd0);
    check({tag, " ram_we"}, 32'(bus.ram_we), 32'd0);
    check({tag, " ram_addr"}, bus.ram_addr, 32'd0);
    check({tag, " ram_wdata"}, bus.ram_wdata, 32'd0);
    check({tag, " vga_en"}, 32'(bus.vga_en), 32'd0);
    check({tag, " vga_we"}, 32'(bus.vga_we), 32'd0);
    check({tag, " vga_addr"}, bus.vga_addr, 32'd0);
    check({tag, " vga_wdata"}, bus.vga_wdata, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) vga_mem[i] = 32'(i) * 32'h0101_0101;
    //          id we  state         addr         wdata        d   ram_data      err rdata         lat ram vga
    set_vec(0,  0, 32'd1,        32'h100,     32'h0,       4,  32'hDEADBEEF, 0, 32'hDEADBEEF, 6,  5,  0);
    set_vec(1,  1, 32'd2,        32'h20,      32'h55,      -1, 32'h0,        0, 32'h0,        3,  0,  1);
    set_vec(2,  0, 32'd2,        32'h20,      32'h0,       -1, 32'h0,        0, 32'h55,       3,  0,  1);
    set_vec(3,  0, 32'd3,        32'h300,     32'h11,      -1, 32'h0,        1, 32'h0,        1,  0,  0);
    set_vec(4,  1, 32'd0,        32'h304,     32'h22,      -1, 32'h0,        1, 32'h0,        1,  0,  0);
    set_vec(5,  0, 32'd7,        32'h308,     32'h33,      -1, 32'h0,        1, 32'h0,        1,  0,  0);
    set_vec(6,  0, 32'h80000001, 32'h30C,     32'h44,      -1, 32'h0,        1, 32'h0,        1,  0,  0);
    set_vec(7,  0, 32'd1,        32'h104,     32'h0,       -1, 32'h0,        1, 32'h0,        17, 16, 0);
    set_vec(8,  0, 32'd1,        32'h108,     32'h0,       15, 32'hCAFEF00D, 0, 32'hCAFEF00D, 17, 16, 0);
    set_vec(9,  1, 32'd1,        32'h44,      32'h1234,    0,  32'hFFFFFFFF, 0, 32'h0,        2,  1,  0);
    set_vec(10, 0, 32'd1,        32'h10C,     32'h0,       14, 32'h13572468, 0, 32'h13572468, 16, 15, 0);
    set_vec(11, 0, 32'd2,        32'h30,      32'h0,       -1, 32'h0,        0, 32'h30303030, 3,  0,  1);

    // Reset held with a request pending: nothing may be accepted.
    rst_n         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_state = 32'd1;
    bus.req_addr  = 32'h100;
    bus.req_wdata = 32'h0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    bus.vga_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset ram_req", 32'(bus.ram_req), 32'd0);
      check("reset req_ready", 32'(bus.req_ready), 32'd1);
    end
    check_reset_outputs("reset");
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Reset in the middle of a RAM wait, then a stray ack.
    @(negedge clk);
    ack_delay     = -1;
    bus.req_we    = 1'b1;
    bus.req_state = 32'd1;
    bus.req_addr  = 32'h1F0;
    bus.req_wdata = 32'hA5A5_A5A5;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst ram_req before", 32'(bus.ram_req), 32'd1);
    check("midrst req_ready busy", 32'(bus.req_ready), 32'd0);
    check("midrst ram_addr before", bus.ram_addr, 32'h1F0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(posedge clk);
    #1 late_ack = 1'b1;
    @(posedge clk);
    #1 late_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("late_ack ram_req", 32'(bus.ram_req), 32'd0);
      check("late_ack resp_valid", 32'(bus.resp_valid), 32'd0);
      check("late_ack req_ready", 32'(bus.req_ready), 32'd1);
      check("late_ack resp_rdata", bus.resp_rdata, 32'd0);
    end

    run_vec(0);
    run_vec(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
- Sits directly downstream of the address translator. Consumes each CPU bus request together with its translated address and its region state code.
- Steers the access to the RAM port (variable latency, ack handshake) or the VGA framebuffer port (fixed 1-cycle read latency).
- Returns a single-cycle response with read data, or an error flag.
- Handles one outstanding transaction at a time, with a bounded-wait timeout on RAM.

Parameters:
- word_width, 32, width of address, data and state-code buses.
- ram_timeout, 16, cycles ram_req may stay high without ram_ack before the access aborts with error (legal range 2..65535).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  router can accept; high only in IDLE.
- req_we  in  1  1=write, 0=read.
- req_addr  in  word_width  translated address from the translator.
- req_state  in  word_width  region code: 1=RAM, 2=VGA, 3=ERR; any other value is treated as ERR.
- req_wdata  in  word_width  write data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  word_width  read data; 0 for writes and errors.
- resp_err  out  1  qualifies resp_valid; access failed.
- ram_req  out  1  RAM request; held until ack or timeout.
- ram_we  out  1  RAM write enable.
- ram_addr  out  word_width  RAM address.
- ram_wdata  out  word_width  RAM write data.
- ram_ack  in  1  RAM completion strobe; read data valid in the same cycle.
- ram_rdata  in  word_width  RAM read data.
- vga_en  out  1  one-cycle VGA access strobe.
- vga_we  out  1  VGA write enable.
- vga_addr  out  word_width  VGA address.
- vga_wdata  out  word_width  VGA write data.
- vga_rdata  in  word_width  VGA read data, valid the cycle after vga_en.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the clk edge.
- Reset values:
  - state=IDLE, so req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - vga_en=0, vga_we=0, vga_addr=0, vga_wdata=0.
  - timeout counter=0.
- Output timing: all outputs are registered, except req_ready, which is (state==IDLE).
- Accept: at the edge where req_valid && req_ready, latch we, addr, wdata and decoded region.
- FSM states: IDLE, RAM_WAIT, VGA_ISSUE, VGA_CAPT, RESP.
- IDLE + accept:
  - region RAM: go to RAM_WAIT; ram_req=1 with we/addr/wdata driven; counter=0.
  - region VGA: go to VGA_ISSUE; vga_en=1 with we/addr/wdata driven.
  - region ERR or unknown code: go to RESP with resp_err=1, resp_rdata=0.
- RAM_WAIT:
  - Each cycle without ack: counter increments.
  - ram_ack=1: ram_req drops, resp_rdata=(we ? 0 : ram_rdata), resp_err=0, go to RESP.
  - Counter reaches ram_timeout-1 without ack: ram_req drops, resp_err=1, resp_rdata=0, go to RESP.
  - ram_ack and timeout in the same cycle: ack wins.
  - ram_req, ram_we, ram_addr and ram_wdata stay stable while ram_req is high.
- VGA_ISSUE: vga_en high for exactly this cycle; go to VGA_CAPT.
- VGA_CAPT: vga_en=0; resp_rdata=(we ? 0 : vga_rdata), resp_err=0; go to RESP. The VGA path never errors.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold their value until the next response.
- Latency from the accept edge to resp_valid high:
  - ERR: 1 cycle.
  - VGA: 3 cycles.
  - RAM: ack cycle + 1.
  - RAM timeout: ram_timeout + 1 cycles.
- A ram_ack arriving in IDLE, VGA or RESP states is ignored.
- req_valid while busy is not consumed. The requester holds its request until req_ready is high.
- Reset asserted mid-transaction: at that edge every output returns to its reset value and no response is issued. A late ram_ack after reset is ignored.

Decomposition:
- Shared package mem_map_pkg holds:
  - region code constants RAM_STATE=1, VGA_STATE=2, ERR_STATE=3;
  - the region base constants used by the translator;
  - the router FSM state typedef, as an enum of 3-bit width.
- One natural sub-module: ram_timeout_ctr. It is a counter with clear/enable and an expired output, sized by $clog2(ram_timeout).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> all outputs 0, req_ready=1; no request is accepted until rst_n=1.
- RAM read: req_state=1, req_addr=0x100, ram_ack asserted 4 cycles after ram_req rises with ram_rdata=0xDEADBEEF -> ram_addr=0x100 while ram_req is high; resp_valid one cycle after ack; resp_rdata=0xDEADBEEF, resp_err=0.
- VGA write then read: write req_state=2, addr=0x20, wdata=0x55 -> vga_en pulse with vga_we=1, vga_wdata=0x55; resp_valid 3 cycles after accept with rdata=0. Then read with vga_rdata=0x55 the cycle after vga_en -> resp_rdata=0x55.
- Error region: req_state=3 (repeat with 0 and 7) -> no ram_req or vga_en; resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0.
- RAM timeout: ram_timeout=16, never ack -> ram_req high exactly 16 cycles; resp_err=1. Repeat with ack on the expiry cycle -> resp_err=0, data returned.
- Reset mid-RAM wait: rst_n=0 while in RAM_WAIT, then ram_ack=1 after release -> ram_req=0, no resp_valid, req_ready=1, ack ignored.
